// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg : shared widths, state encoding and helpers for pipe_stage_reg     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int MEM_CTRL_W = 13;
  localparam int WB_CTRL_W  = 10;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // A bubble is the all-zero control word, which downstream decodes as a NOP.
  localparam int BUBBLE_W_DEFAULT = MEM_CTRL_W + WB_CTRL_W;
  localparam logic [BUBBLE_W_DEFAULT-1:0] BUBBLE_DEFAULT = '0;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg_if : valid/ready handshake bundle between pipeline stages    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pipe_stage_reg_if #(
  parameter int MEM_W = pipe_pkg::MEM_CTRL_W,
  parameter int WB_W  = pipe_pkg::WB_CTRL_W
);
  logic             in_valid;
  logic             in_ready;
  logic [MEM_W-1:0] in_mem;
  logic [WB_W-1:0]  in_wb;
  logic             out_valid;
  logic             out_ready;
  logic [MEM_W-1:0] out_mem;
  logic [WB_W-1:0]  out_wb;

  modport master (
    output in_valid, in_mem, in_wb, out_ready,
    input  in_ready, out_valid, out_mem, out_wb
  );

  modport slave (
    input  in_valid, in_mem, in_wb, out_ready,
    output in_ready, out_valid, out_mem, out_wb
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_slot : valid + payload register with load, drop and synchronous clear  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_slot #(
  parameter int W = pipe_pkg::BUBBLE_W_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_clr,
  input  wire logic         i_load,
  input  wire logic         i_drop,
  input  wire logic [W-1:0] i_data,
  output logic              o_valid,
  output logic [W-1:0]      o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Payload is zeroed whenever the slot empties so an idle slot holds a bubble.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drop) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg : inter-stage control register, stall/flush, optional skid   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int MEM_W   = MEM_CTRL_W,
  parameter int WB_W    = WB_CTRL_W,
  parameter bit SKID_EN = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_flush,
  pipe_stage_reg_if.slave   bus,
  output logic [1:0]        o_occupancy
);

  localparam int SLOT_W = MEM_W + WB_W;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [SLOT_W-1:0] w_in_data;
  logic [SLOT_W-1:0] w_main_din;
  logic [SLOT_W-1:0] w_main_data;
  logic [SLOT_W-1:0] w_skid_data;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_main_load;
  logic              w_main_drop;
  logic              w_skid_load;
  logic              w_skid_drop;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_data  = {bus.in_mem, bus.in_wb};
  assign w_in_fire  = bus.in_valid & bus.in_ready;
  assign w_out_fire = w_main_valid & bus.out_ready;

  // With the skid slot, in_ready looks only at held state, breaking the out_ready path.
  assign bus.in_ready = SKID_EN ? (rst & ~w_skid_valid)
                                : (rst & (~w_main_valid | bus.out_ready));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = SKID_EN ? ST_FULL : ST_ONE;
          else if (!w_in_fire && w_out_fire) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_out_fire) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_main_load = 1'b0;
    w_main_drop = 1'b0;
    w_skid_load = 1'b0;
    w_skid_drop = 1'b0;
    w_main_din  = w_in_data;
    if (!i_flush) begin
      case (r_state)
        ST_EMPTY: w_main_load = w_in_fire;
        ST_ONE: begin
          if (w_in_fire && w_out_fire) w_main_load = 1'b1;
          else if (w_in_fire)          w_skid_load = SKID_EN;
          else if (w_out_fire)         w_main_drop = 1'b1;
        end
        ST_FULL: begin
          // Skid entry advances to the head only as the old head leaves: FIFO order.
          if (w_out_fire) begin
            w_main_load = 1'b1;
            w_main_din  = w_skid_data;
            w_skid_drop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_flush),
    .i_load  (w_main_load),
    .i_drop  (w_main_drop),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(.W(SLOT_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (i_flush),
        .i_load  (w_skid_load),
        .i_drop  (w_skid_drop),
        .i_data  (w_in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
    end
  endgenerate

  assign bus.out_valid = w_main_valid;
  assign bus.out_mem   = w_main_valid ? w_main_data[SLOT_W-1:WB_W] : '0;
  assign bus.out_wb    = w_main_valid ? w_main_data[WB_W-1:0]      : '0;
  assign o_occupancy   = occ_count(w_main_valid, w_skid_valid);

endmodule
`default_nettype wire
